// File: rtl/pw_channel_serializer_pkg.sv
// pw_pkg: shared state encoding, width helpers and group-count clamp for the PW pre-processing path.
// Ports: none (package only).
package pw_pkg;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_EMIT = 1'b1;
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
    function automatic int clamp_groups(input int cfg, input int max_g);
        return (cfg == 0) ? 1 : ((cfg > max_g) ? max_g : cfg);
    endfunction
    function automatic int slice_width(input int dw, input int gc);
        return dw * gc;
    endfunction
    function automatic int total_width(input int dw, input int gc, input int ng);
        return dw * gc * ng;
    endfunction
endpackage

// File: rtl/pw_channel_serializer_slice_mux.sv
// pw_slice_mux: combinational selection of one SLICE_W slice from the latched channel vector.
// Ports: vec_i full vector, idx_i slice index, slice_o selected slice (zero when idx_i is out of range).
module pw_slice_mux
    import pw_pkg::*;
#(
    parameter int SLICE_W    = 72,
    parameter int NUM_GROUPS = 2,
    parameter int GRP_IDX_W  = clog2_min1(NUM_GROUPS)
) (
    input  logic [SLICE_W*NUM_GROUPS-1:0] vec_i,
    input  logic [GRP_IDX_W-1:0]          idx_i,
    output logic [SLICE_W-1:0]            slice_o
);
    always_comb begin
        slice_o = '0;
        for (int g = 0; g < NUM_GROUPS; g++)
            if (idx_i == GRP_IDX_W'(g)) slice_o = vec_i[g*SLICE_W +: SLICE_W];
    end
endmodule

// File: rtl/pw_channel_serializer.sv
// pw_channel_serializer: splits a NUM_GROUPS*GROUP_CH channel vector into GROUP_CH-wide slices with valid/ready.
// Ports: in_data/in_valid/in_ready input vector handshake, cfg_groups slice count (sampled on accept),
//        out_data/out_grp/out_last/out_valid/out_ready slice stream handshake, clk, rstn (async, active-low).
module pw_channel_serializer
    import pw_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int GROUP_CH       = 9,
    parameter int NUM_GROUPS     = 2,
    parameter int GRP_IDX_W      = clog2_min1(NUM_GROUPS),
    parameter int SLICE_W        = slice_width(DATA_WIDTH, GROUP_CH),
    parameter int TOTAL_IN_WIDTH = total_width(DATA_WIDTH, GROUP_CH, NUM_GROUPS)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [TOTAL_IN_WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [GRP_IDX_W:0]        cfg_groups,
    output logic [SLICE_W-1:0]        out_data,
    output logic [GRP_IDX_W-1:0]      out_grp,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready
);
    logic                      state_q, state_d;
    logic [TOTAL_IN_WIDTH-1:0] vec_q, vec_d;
    logic [GRP_IDX_W:0]        ng_q, ng_d, ng_in;
    logic [GRP_IDX_W-1:0]      grp_q, grp_d, grp_nxt;
    logic [SLICE_W-1:0]        data_q, data_d, next_slice;
    logic                      last_q, last_d, valid_q, valid_d;
    logic                      accept, out_xfer;

    assign grp_nxt  = grp_q + 1'b1;
    assign ng_in    = (GRP_IDX_W+1)'(clamp_groups(int'(cfg_groups), NUM_GROUPS));
    assign accept   = in_valid && in_ready;
    assign out_xfer = valid_q && out_ready;

    pw_slice_mux #(.SLICE_W(SLICE_W), .NUM_GROUPS(NUM_GROUPS), .GRP_IDX_W(GRP_IDX_W)) u_mux (
        .vec_i  (vec_q),
        .idx_i  (grp_nxt),
        .slice_o(next_slice)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            ng_q    <= '0;
            grp_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            ng_q    <= ng_d;
            grp_q   <= grp_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    // Accept has priority: it covers both IDLE and the zero-bubble reload on the final slice.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ng_d    = ng_q;
        grp_d   = grp_q;
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (accept) begin
            state_d = ST_EMIT;
            vec_d   = in_data;
            ng_d    = ng_in;
            grp_d   = '0;
            data_d  = in_data[SLICE_W-1:0];
            last_d  = ng_in == (GRP_IDX_W+1)'(1);
            valid_d = 1'b1;
        end else if (out_xfer && !last_q) begin
            grp_d   = grp_nxt;
            data_d  = next_slice;
            last_d  = (GRP_IDX_W+1)'(grp_q) + (GRP_IDX_W+1)'(1) == ng_q - (GRP_IDX_W+1)'(1);
        end else if (out_xfer) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE) || (valid_q && last_q && out_ready);
        out_data  = data_q;
        out_grp   = grp_q;
        out_last  = last_q;
        out_valid = valid_q;
    end
endmodule

// File: tb/tb_pw_channel_serializer.sv
// tb_pw_channel_serializer: directed self-checking bench for pw_channel_serializer at default parameters.
module tb_pw_channel_serializer;
    localparam int SW = 72;
    localparam int TW = 144;

    logic          clk = 1'b0;
    logic          rstn;
    logic [TW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    cfg_groups;
    logic [SW-1:0] out_data;
    logic [0:0]    out_grp;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;

    int vec_n = 0;
    int err_n = 0;

    pw_channel_serializer dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cfg_groups(cfg_groups),
        .out_data  (out_data),
        .out_grp   (out_grp),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Vector whose channel k holds base+k.
    function automatic logic [TW-1:0] mk_vec(input int base);
        logic [TW-1:0] v;
        for (int k = 0; k < 18; k++) v[k*8 +: 8] = 8'(base + k);
        return v;
    endfunction

    // Slice whose channel j holds base+j.
    function automatic logic [SW-1:0] mk_slice(input int base);
        logic [SW-1:0] s;
        for (int j = 0; j < 9; j++) s[j*8 +: 8] = 8'(base + j);
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; cfg_groups = 2'd2; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) rstn = 1'b1;
            step();
            vec_n++;
            if ({out_valid, in_ready} !== 2'b01) begin
                err_n++; $display("FAIL reset_hs cyc%0d got v/r=%b want 01", i, {out_valid, in_ready});
            end
            vec_n++;
            if (out_data !== '0) begin
                err_n++; $display("FAIL reset_data cyc%0d got %h want 0", i, out_data);
            end
        end
    endtask

    task automatic test_basic_split();
        in_data = mk_vec(1); cfg_groups = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        vec_n++;
        if (in_ready !== 1'b1) begin err_n++; $display("FAIL basic_rdy_idle got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        vec_n++;
        if ({out_valid, out_grp, out_last, in_ready} !== 4'b1000) begin
            err_n++; $display("FAIL basic_s0_ctl got %b want 1000", {out_valid, out_grp, out_last, in_ready});
        end
        vec_n++;
        if (out_data !== mk_slice(1)) begin err_n++; $display("FAIL basic_s0_data got %h want %h", out_data, mk_slice(1)); end
        step();
        vec_n++;
        if ({out_valid, out_grp, out_last, in_ready} !== 4'b1111) begin
            err_n++; $display("FAIL basic_s1_ctl got %b want 1111", {out_valid, out_grp, out_last, in_ready});
        end
        vec_n++;
        if (out_data !== mk_slice(10)) begin err_n++; $display("FAIL basic_s1_data got %h want %h", out_data, mk_slice(10)); end
        step();
        vec_n++;
        if ({out_valid, in_ready} !== 2'b01) begin err_n++; $display("FAIL basic_idle got v/r=%b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_backpressure();
        in_data = mk_vec(1); cfg_groups = 2'd2; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0; in_data = mk_vec(200);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            vec_n++;
            if ({out_valid, out_grp, out_last, in_ready} !== 4'b1000) begin
                err_n++; $display("FAIL bp_hold_ctl cyc%0d got %b want 1000", i, {out_valid, out_grp, out_last, in_ready});
            end
            vec_n++;
            if (out_data !== mk_slice(1)) begin err_n++; $display("FAIL bp_hold_data cyc%0d got %h want %h", i, out_data, mk_slice(1)); end
        end
        out_ready = 1'b1;
        step();
        vec_n++;
        if ({out_valid, out_grp, out_last} !== 3'b111) begin
            err_n++; $display("FAIL bp_s1_ctl got %b want 111", {out_valid, out_grp, out_last});
        end
        vec_n++;
        if (out_data !== mk_slice(10)) begin err_n++; $display("FAIL bp_s1_data got %h want %h", out_data, mk_slice(10)); end
        step();
        vec_n++;
        if (out_valid !== 1'b0) begin err_n++; $display("FAIL bp_done got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        in_data = mk_vec(1); cfg_groups = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_data = mk_vec(101);
        vec_n++;
        if ({out_valid, out_grp, out_last, in_ready, out_data} !== {4'b1000, mk_slice(1)}) begin
            err_n++; $display("FAIL b2b_a0 got %b/%h want 1000/%h", {out_valid, out_grp, out_last, in_ready}, out_data, mk_slice(1));
        end
        step();
        vec_n++;
        if ({out_valid, out_grp, out_last, in_ready, out_data} !== {4'b1111, mk_slice(10)}) begin
            err_n++; $display("FAIL b2b_a1 got %b/%h want 1111/%h", {out_valid, out_grp, out_last, in_ready}, out_data, mk_slice(10));
        end
        step();
        in_valid = 1'b0;
        vec_n++;
        if ({out_valid, out_grp, out_last, in_ready, out_data} !== {4'b1000, mk_slice(101)}) begin
            err_n++; $display("FAIL b2b_b0 got %b/%h want 1000/%h", {out_valid, out_grp, out_last, in_ready}, out_data, mk_slice(101));
        end
        step();
        vec_n++;
        if ({out_valid, out_grp, out_last, in_ready, out_data} !== {4'b1111, mk_slice(110)}) begin
            err_n++; $display("FAIL b2b_b1 got %b/%h want 1111/%h", {out_valid, out_grp, out_last, in_ready}, out_data, mk_slice(110));
        end
        step();
        vec_n++;
        if (out_valid !== 1'b0) begin err_n++; $display("FAIL b2b_done got %b want 0", out_valid); end
    endtask

    task automatic test_clamp();
        in_data = mk_vec(41); cfg_groups = 2'd0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        vec_n++;
        if ({out_valid, out_grp, out_last, in_ready, out_data} !== {4'b1011, mk_slice(41)}) begin
            err_n++; $display("FAIL clamp0_s0 got %b/%h want 1011/%h", {out_valid, out_grp, out_last, in_ready}, out_data, mk_slice(41));
        end
        step();
        vec_n++;
        if (out_valid !== 1'b0) begin err_n++; $display("FAIL clamp0_done got %b want 0", out_valid); end
        in_data = mk_vec(61); cfg_groups = 2'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0; cfg_groups = 2'd1;
        vec_n++;
        if ({out_valid, out_grp, out_last, out_data} !== {3'b100, mk_slice(61)}) begin
            err_n++; $display("FAIL clamp3_s0 got %b/%h want 100/%h", {out_valid, out_grp, out_last}, out_data, mk_slice(61));
        end
        step();
        vec_n++;
        if ({out_valid, out_grp, out_last, out_data} !== {3'b111, mk_slice(70)}) begin
            err_n++; $display("FAIL clamp3_s1 got %b/%h want 111/%h", {out_valid, out_grp, out_last}, out_data, mk_slice(70));
        end
        step();
        vec_n++;
        if (out_valid !== 1'b0) begin err_n++; $display("FAIL clamp3_done got %b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        in_data = mk_vec(1); cfg_groups = 2'd2; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        vec_n++;
        if (out_valid !== 1'b1) begin err_n++; $display("FAIL arst_pre got %b want 1", out_valid); end
        #2 rstn = 1'b0;
        #1;
        vec_n++;
        if ({out_valid, out_grp, out_last, in_ready} !== 4'b0001) begin
            err_n++; $display("FAIL arst_ctl got %b want 0001", {out_valid, out_grp, out_last, in_ready});
        end
        vec_n++;
        if (out_data !== '0) begin err_n++; $display("FAIL arst_data got %h want 0", out_data); end
        step();
        rstn = 1'b1; out_ready = 1'b1;
        step();
        in_data = mk_vec(201); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vec_n++;
        if ({out_valid, out_grp, out_last, out_data} !== {3'b100, mk_slice(201)}) begin
            err_n++; $display("FAIL arst_c0 got %b/%h want 100/%h", {out_valid, out_grp, out_last}, out_data, mk_slice(201));
        end
        step();
        vec_n++;
        if ({out_valid, out_grp, out_last, out_data} !== {3'b111, mk_slice(210)}) begin
            err_n++; $display("FAIL arst_c1 got %b/%h want 111/%h", {out_valid, out_grp, out_last}, out_data, mk_slice(210));
        end
        step();
        vec_n++;
        if (out_valid !== 1'b0) begin err_n++; $display("FAIL arst_done got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_split();
        test_backpressure();
        test_back_to_back();
        test_clamp();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end
endmodule

// File: doc/pw_channel_serializer.md
Name: pw_channel_serializer

Overview:
- Generalised pointwise-conv pre-processor. Accepts a wide vector of NUM_GROUPS*GROUP_CH channels and emits it as a sequence of GROUP_CH-channel slices to the PW MAC array.
- Adds valid/ready flow control, a runtime-selectable group count and a last-slice flag. The previous free-running two-phase splitter had none of these.
- Sits between the depthwise output stage and the PW conv unit.

Parameters:
- DATA_WIDTH, 8, bits per channel sample.
- GROUP_CH, 9, channels per emitted slice (PW input-channel width).
- NUM_GROUPS, 2, maximum slices per input vector; must be ≥1.
- GRP_IDX_W, $clog2(NUM_GROUPS) min 1, width of the group index/count fields.
- SLICE_W, DATA_WIDTH*GROUP_CH, derived slice width.
- TOTAL_IN_WIDTH, SLICE_W*NUM_GROUPS, derived input width.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset. Asynchronous, active-low.
- in_data  in  TOTAL_IN_WIDTH  full channel vector; slice g = bits [g*SLICE_W +: SLICE_W].
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a vector this cycle.
- cfg_groups  in  GRP_IDX_W+1  number of slices to emit for this vector; sampled on accept.
- out_data  out  SLICE_W  current slice.
- out_grp  out  GRP_IDX_W  index of current slice.
- out_last  out  1  current slice is the final one of its vector.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the slice.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous, active-low.
- Reset values: out_data=0, out_grp=0, out_last=0, out_valid=0, internal vector register=0, state=IDLE. in_ready is combinational and therefore reads 1 during and after reset.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Effective count ng = cfg_groups, clamped at accept time:
  - 0 is treated as 1.
  - Values above NUM_GROUPS become NUM_GROUPS.
- FSM states: IDLE and EMIT.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On input transfer: latch the vector and ng. Load out_data=slice0, out_grp=0, out_last=(ng==1), out_valid=1. Go to EMIT.
  - Latency: accept at edge N, slice 0 visible after edge N, i.e. one cycle.
- EMIT, no output transfer: all outputs hold stable (hold-under-backpressure rule).
- EMIT, output transfer and not out_last: advance to the next slice. out_grp+1, out_data=next slice, out_last=(out_grp+1==ng-1).
- EMIT, output transfer and out_last:
  - If in_valid is also high, the new vector is accepted in the same cycle. Its slice 0 is loaded directly, giving zero bubble. Stay in EMIT.
  - Otherwise out_valid=0 and go to IDLE.
- in_ready rule: in_ready = (state==IDLE) || (out_valid && out_last && out_ready). This is combinational from out_ready and registered state only. It never depends combinationally on in_valid.
- Throughput: one slice per cycle with no backpressure, including across vector boundaries.
- in_data and cfg_groups are don't-care when not accepted. A change in cfg_groups mid-vector has no effect on the current vector.
- Reset asserted mid-vector: remaining slices are dropped, all outputs return to reset values immediately (async), and the block restarts in IDLE.
- NUM_GROUPS=1: every slice has out_last=1 and out_grp=0. The block degenerates to a registered skid-free pass-through.

Decomposition:
- Shared package pw_pkg holds:
  - The state encoding localparams (ST_IDLE, ST_EMIT).
  - Helper functions clog2_min1 and clamp_groups.
  - The derived SLICE_W / TOTAL_IN_WIDTH expressions, reused by the PW conv unit.
- One natural sub-module, pw_slice_mux: a purely combinational indexed part-select of the latched vector by group index. The FSM, counters and registers stay in the top module.

Test Plan:
- Reset-then-idle: hold rstn=0 for 3 cycles, release, keep in_valid=0 → out_valid=0, in_ready=1, out_data=0 throughout.
- Basic split (defaults): vector with channel k = k+1 (k=0..17), cfg_groups=2, out_ready=1 →
  - Cycle 1: out_data carries channels 1..9, grp=0, last=0.
  - Cycle 2: channels 10..18, grp=1, last=1.
  - in_ready low during cycle 1.
- Backpressure: same vector, out_ready=0 for 4 cycles after the first out_valid → out_data/out_grp/out_last stable for 4 cycles, in_ready=0; slices then delivered in order once out_ready=1.
- Back-to-back vectors: in_valid held high with vectors A and B, out_ready=1 → slices A0, A1, B0, B1 on 4 consecutive cycles. in_ready pulses exactly on the A1 transfer cycle.
- Group clamp: cfg_groups=0 → single slice, grp=0, last=1. cfg_groups=3 with NUM_GROUPS=2 → exactly 2 slices.
- Async reset mid-vector: assert rstn=0 while slice 0 is pending under backpressure → out_valid drops without a clock edge. After release, new vector C emits C0 first, with no residue from the dropped vector.
